step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Command-level front end for the stepper motor drive FSM. Accepts a move
//  command (direction, step count, step period) via start/busy handshake and
//  emits one-cycle forw/rev pulses, one per motor step, spaced by the period.
//  Sits directly upstream of the motor drive FSM and shares its drv_clk.
//  The motor FSM advances one phase per cycle of forw/rev; the pulse width is
//  therefore exactly one drv_clk cycle.
// PARAMETERS
//  STEP_W  8  width of step count and steps_left
//  PER_W   8  width of step period / inter-step delay counter
// PORTS
//  drv_clk     in   1       single clock, all state on posedge
//  reset       in   1       asynchronous, active-high; clears all state
//  start       in   1       command strobe, sampled only in IDLE
//  dir         in   1       0 = forward (forw), 1 = reverse (rev); latched on start
//  steps       in   STEP_W  number of steps to issue; latched on start
//  period      in   PER_W   idle cycles before each step (0 treated as 1)
//  abort       in   1       terminate current command early
//  forw        out  1       one-cycle forward step pulse to motor FSM
//  rev         out  1       one-cycle reverse step pulse to motor FSM
//  busy        out  1       high in WAIT, STEP, DONE
//  cmd_done    out  1       one-cycle pulse in DONE
//  steps_left  out  STEP_W  steps remaining in current command
// BEHAVIOUR
//  Reset (async, reset=1): state=IDLE; forw=rev=busy=cmd_done=0; steps_left=0;
//   latched dir/period=0; delay counter=0. Reset mid-move drops pulses at once.
//  States: IDLE, WAIT, STEP, DONE. All outputs Moore, decoded from registered
//   state; no combinational input-to-output paths.
//  IDLE: start=1 & steps!=0 -> WAIT; latch dir, steps_left=steps,
//   cnt=max(period,1). start=1 & steps==0 -> DONE (no pulses).
//   start=0 -> stay. abort ignored in IDLE.
//  WAIT: cnt==1 -> STEP; else cnt<=cnt-1. abort=1 -> DONE (priority over cnt).
//  STEP: forw=~dir_q, rev=dir_q for exactly this cycle. On exit steps_left
//   decrements by 1; result==0 or abort=1 -> DONE; else WAIT, cnt reloaded.
//   abort coincident with STEP: the step is still issued and counted.
//  DONE: cmd_done=1, busy=1 for one cycle -> IDLE unconditionally.
//   steps_left holds its final value (0, or remainder if aborted) until next
//   accepted start.
//  Timing: start accepted at edge k, period P>=1 -> first pulse in cycle
//   k+P+1; subsequent pulses every P+1 cycles; cmd_done in cycle after last
//   pulse. Total command length N*(P+1)+1 cycles after acceptance.
//  forw and rev never both high. start while busy is ignored (not queued).
//  Widths: steps_left and cnt are unsigned, never wrap below 0 (decrement only
//   when nonzero). steps=2^STEP_W-1 and period=2^PER_W-1 fully supported.
// TESTING
//  1 reset, start dir=0 steps=3 period=2 -> forw pulses in cycles 3,6,9 after
//    accept; rev=0; cmd_done cycle 10; steps_left 3,2,1,0.
//  2 dir=1 steps=4 period=0 -> rev pulses every 2 cycles (cycles 2,4,6,8);
//    forw=0 throughout; busy low at cycle 10.
//  3 steps=0 start -> cmd_done one cycle later, no forw/rev, steps_left=0.
//  4 steps=5 period=3, abort asserted during WAIT after 2nd pulse -> no more
//    pulses; DONE next cycle; steps_left=3.
//  5 abort coincident with STEP on pulse 1 of steps=5 -> pulse issued,
//    steps_left=4, cmd_done next cycle.
//  6 assert reset asynchronously mid-WAIT and mid-STEP -> forw/rev/busy drop
//    before next edge; second start while busy=1 ignored; chained into motor
//    FSM, 4 forw pulses return phase to 4'b0001.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: turns a move command into one-cycle forw/rev step pulses spaced by a period
module step_sequencer #(
  parameter int STEP_W = 8,
  parameter int PER_W  = 8
) (
  input  logic              drv_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic [PER_W-1:0]  period,
  input  logic              abort,
  output logic              forw,
  output logic              rev,
  output logic              busy,
  output logic              cmd_done,
  output logic [STEP_W-1:0] steps_left
);
  typedef enum logic [1:0] {IDLE, WAIT, STEP, DONE} state_t;
  state_t state, state_nx;
  logic dir_q, dir_nx;
  logic [PER_W-1:0] per_q, per_nx, cnt, cnt_nx;
  logic [STEP_W-1:0] steps_nx;
  always_ff @(posedge drv_clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      per_q      <= '0;
      cnt        <= '0;
      steps_left <= '0;
    end else begin
      state      <= state_nx;
      dir_q      <= dir_nx;
      per_q      <= per_nx;
      cnt        <= cnt_nx;
      steps_left <= steps_nx;
    end
  // per_q holds the period already clamped to at least 1, so reloads need no check
  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    per_nx   = per_q;
    cnt_nx   = cnt;
    steps_nx = steps_left;
    case (state)
      IDLE: if (start) begin
        steps_nx = steps;
        if (steps != '0) begin
          state_nx = WAIT;
          dir_nx   = dir;
          per_nx   = (period == '0) ? PER_W'(1) : period;
          cnt_nx   = per_nx;
        end else state_nx = DONE;
      end
      WAIT: begin
        state_nx = abort ? DONE : (cnt == PER_W'(1)) ? STEP : WAIT;
        cnt_nx   = (abort || cnt == PER_W'(1)) ? cnt : cnt - PER_W'(cnt != '0);
      end
      STEP: begin
        steps_nx = steps_left - STEP_W'(steps_left != '0);
        state_nx = (steps_nx == '0 || abort) ? DONE : WAIT;
        cnt_nx   = per_q;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign forw     = (state == STEP) & ~dir_q;
  assign rev      = (state == STEP) & dir_q;
  assign busy     = (state != IDLE);
  assign cmd_done = (state == DONE);
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed checks of pulse timing, abort, reset and motor phase chaining
module tb_step_sequencer;
  logic drv_clk = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0, abort = 1'b0;
  logic [7:0] steps = '0, period = '0;
  logic forw, rev, busy, cmd_done;
  logic [7:0] steps_left;
  logic [31:0] fm, rm, dm, bm;
  logic [7:0] sl_hist [0:31];
  logic [3:0] phase;
  int tests = 0, fails = 0;

  step_sequencer dut (
    .drv_clk(drv_clk), .reset(reset), .start(start), .dir(dir), .steps(steps),
    .period(period), .abort(abort), .forw(forw), .rev(rev), .busy(busy),
    .cmd_done(cmd_done), .steps_left(steps_left)
  );

  always #5 drv_clk = ~drv_clk;

  // downstream motor phase: rotate left on forw, right on rev
  always_ff @(posedge drv_clk or posedge reset)
    if (reset) phase <= 4'b0001;
    else if (forw) phase <= {phase[2:0], phase[3]};
    else if (rev) phase <= {phase[0], phase[3:1]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // cycle c = interval after the c-th edge following the accepting edge
  task automatic run(input logic d, input logic [7:0] s, input logic [7:0] p,
                     input int n, input int ab, input int bump);
    @(negedge drv_clk);
    start = 1'b1; dir = d; steps = s; period = p;
    @(negedge drv_clk);
    fm = '0; rm = '0; dm = '0; bm = '0;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge drv_clk);
      fm[c] = forw; rm[c] = rev; dm[c] = cmd_done; bm[c] = busy;
      sl_hist[c] = steps_left;
      abort = (c == ab);
      if (c == bump) begin
        start = 1'b1; dir = ~d; steps = 8'd7;
      end else start = 1'b0;
    end
    abort = 1'b0; start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge drv_clk);
    check("rst_busy", busy, 0);
    check("rst_pulses", {forw, rev, cmd_done}, 0);
    check("rst_left", steps_left, 0);
    reset = 1'b0;

    run(0, 8'd3, 8'd2, 11, 0, 0);
    check("t1_forw", fm, 32'h248);
    check("t1_rev", rm, 0);
    check("t1_done", dm, 32'h400);
    check("t1_busy", bm, 32'h7FE);
    check("t1_left", {sl_hist[3], sl_hist[4], sl_hist[7], sl_hist[10]}, 32'h03020100);

    run(1, 8'd4, 8'd0, 10, 0, 0);
    check("t2_rev", rm, 32'h154);
    check("t2_forw", fm, 0);
    check("t2_done", dm, 32'h200);
    check("t2_busy", bm, 32'h3FE);

    run(0, 8'd0, 8'd5, 3, 0, 0);
    check("t3_done", dm, 32'h2);
    check("t3_pulses", fm | rm, 0);
    check("t3_left", sl_hist[1], 0);
    check("t3_busy", bm, 32'h2);

    run(0, 8'd5, 8'd3, 12, 9, 0);
    check("t4_forw", fm, 32'h110);
    check("t4_done", dm, 32'h400);
    check("t4_left", sl_hist[10], 3);
    check("t4_busy", bm, 32'h7FE);

    run(1, 8'd5, 8'd3, 6, 4, 0);
    check("t5_rev", rm, 32'h10);
    check("t5_forw", fm, 0);
    check("t5_done", dm, 32'h20);
    check("t5_left", sl_hist[5], 4);

    @(negedge drv_clk);
    start = 1'b1; dir = 1'b0; steps = 8'd3; period = 8'd2;
    @(negedge drv_clk);
    start = 1'b0;
    check("t6_wait_busy", busy, 1);
    #2 reset = 1'b1;
    #1 check("t6_wait_rst", {busy, forw, rev}, 0);
    @(negedge drv_clk) reset = 1'b0;

    @(negedge drv_clk);
    start = 1'b1; dir = 1'b1; steps = 8'd3; period = 8'd2;
    @(negedge drv_clk);
    start = 1'b0;
    repeat (2) @(negedge drv_clk);
    check("t6_step_rev", rev, 1);
    #2 reset = 1'b1;
    #1 check("t6_step_rst", {busy, forw, rev}, 0);
    check("t6_step_left", steps_left, 0);
    @(negedge drv_clk) reset = 1'b0;

    run(0, 8'd4, 8'd1, 10, 0, 0);
    check("t6_motor_forw", fm, 32'h154);
    check("t6_motor_phase", phase, 4'b0001);

    run(0, 8'd2, 8'd1, 7, 0, 1);
    check("t6_ign_forw", fm, 32'h14);
    check("t6_ign_rev", rm, 0);
    check("t6_ign_done", dm, 32'h20);
    check("t6_ign_busy", bm, 32'h3E);
    check("t6_ign_left", sl_hist[5], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
